// File: rtl/sm_imem_loader.sv
// Byte-stream bootloader: framed image -> 32-bit little-endian words on the imem write port.
// Optional trailing XOR checksum byte when SM_LOADER_CHECKSUM_EN is defined.
module sm_imem_loader #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_waddr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
`ifdef SM_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           widx_q, widx_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [31:0]           asm_q, asm_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
`ifdef SM_LOADER_CHECKSUM_EN
    logic [7:0]            cks_q, cks_d;
`endif

    logic   accept;
    logic   hdr_hit;
    logic   ovf;
    state_t fin_state;

    assign in_ready = (state_q != ST_WRITE);
    assign accept   = in_valid && in_ready;
    assign hdr_hit  = accept && (in_data == SYNC_BYTE)
                      && ((state_q == ST_SYNC) || (state_q == ST_RUN));
    assign ovf      = (32'(widx_q) >= DEPTH);

    // End of payload: checksum byte if enabled, else straight to RUN unless an overflow poisoned the frame.
`ifdef SM_LOADER_CHECKSUM_EN
    assign fin_state = ST_CHECK;
`else
    assign fin_state = err_q ? ST_SYNC : ST_RUN;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
`ifdef SM_LOADER_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        if (hdr_hit) begin
            err_d   = 1'b0;
            widx_d  = '0;
            bcnt_d  = '0;
`ifdef SM_LOADER_CHECKSUM_EN
            cks_d   = '0;
`endif
            state_d = ST_LEN0;
        end else begin
            case (state_q)
                ST_LEN0: begin
                    if (accept) begin
                        len_d[7:0] = in_data;
                        state_d    = ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (accept) begin
                        len_d[15:8] = in_data;
                        state_d     = ({in_data, len_q[7:0]} == 16'd0) ? fin_state : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        asm_d[8*bcnt_q +: 8] = in_data;
                        bcnt_d = bcnt_q + 2'd1;
`ifdef SM_LOADER_CHECKSUM_EN
                        cks_d  = cks_q ^ in_data;
`endif
                        if (bcnt_q == 2'd3) begin
                            state_d = ST_WRITE;
                            if (ovf) begin
                                err_d = 1'b1;
                            end else begin
                                we_d    = 1'b1;
                                waddr_d = widx_q[ADDR_WIDTH-1:0];
                                wdata_d = {in_data, asm_q[23:0]};
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    widx_d  = widx_q + 16'd1;
                    state_d = ({1'b0, widx_q} + 17'd1 < {1'b0, len_q}) ? ST_DATA : fin_state;
                end
`ifdef SM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        if ((in_data == cks_q) && !err_q) begin
                            state_d = ST_RUN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_SYNC;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
        // Registered: rise one cycle after RUN is entered, drop on the edge that leaves it.
        done_d      = (state_q == ST_RUN) && (state_d == ST_RUN);
        cpu_rst_n_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SYNC;
            len_q       <= '0;
            widx_q      <= '0;
            bcnt_q      <= '0;
            asm_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef SM_LOADER_CHECKSUM_EN
            cks_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef SM_LOADER_CHECKSUM_EN
            cks_q       <= cks_d;
`endif
        end
    end

    assign im_we     = we_q;
    assign im_waddr  = waddr_q;
    assign im_wdata  = wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_SYNC) && (state_q != ST_RUN);

endmodule

// File: tb/tb_sm_imem_loader.sv
// Scoreboard bench for sm_imem_loader: two instances (64-word and 2-word memories) share one byte stream.
module tb_sm_imem_loader;

    localparam int unsigned AW_A    = 6;
    localparam int unsigned AW_B    = 1;
    localparam int          DEPTH_A = 64;
    localparam int          DEPTH_B = 2;
    localparam logic [7:0]  SYNC    = 8'hA5;
`ifdef SM_LOADER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      in_data = '0;
    logic            in_valid = 1'b0;

    logic            in_ready_a, im_we_a, cpu_rst_n_a, busy_a, done_a, err_a;
    logic [AW_A-1:0] im_waddr_a;
    logic [31:0]     im_wdata_a;
    logic            in_ready_b, im_we_b, cpu_rst_n_b, busy_b, done_b, err_b;
    logic [AW_B-1:0] im_waddr_b;
    logic [31:0]     im_wdata_b;

    always #5 clk = ~clk;

    sm_imem_loader #(.ADDR_WIDTH(AW_A), .SYNC_BYTE(SYNC)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .im_we(im_we_a), .im_waddr(im_waddr_a), .im_wdata(im_wdata_a), .cpu_rst_n(cpu_rst_n_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    sm_imem_loader #(.ADDR_WIDTH(AW_B), .SYNC_BYTE(SYNC)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .im_we(im_we_b), .im_waddr(im_waddr_b), .im_wdata(im_wdata_b), .cpu_rst_n(cpu_rst_n_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    int          total = 0;
    int          bad = 0;
    logic [47:0] exp_a[$];
    logic [47:0] exp_b[$];
    logic [31:0] words[$];
    bit          gaps = 1'b0;
    bit          ok_a = 1'b0;
    bit          ok_b = 1'b0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Write monitors: every im_we pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (im_we_a === 1'b1) begin
            check("ready_low_in_write_a", 48'(in_ready_a), 48'd0);
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write_a: got addr %0h data %0h expected no write", im_waddr_a, im_wdata_a);
            end else begin
                check("write_a", {10'b0, im_waddr_a, im_wdata_a}, exp_a.pop_front());
            end
        end
        if (im_we_b === 1'b1) begin
            check("ready_low_in_write_b", 48'(in_ready_b), 48'd0);
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write_b: got addr %0h data %0h expected no write", im_waddr_b, im_wdata_b);
            end else begin
                check("write_b", {15'b0, im_waddr_b, im_wdata_b}, exp_b.pop_front());
            end
        end
    end

    task automatic idle(input int unsigned k);
        in_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit sent = 1'b0;
        if (gaps && ($urandom_range(3) == 0)) idle($urandom_range(3, 1));
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 8 && !sent; n++) begin
            sent = in_ready_a && in_ready_b;
            @(negedge clk);
        end
        if (!sent) begin
            total++; bad++;
            $display("FAIL send_byte: byte %0h not accepted within 8 cycles", b);
        end
    endtask

    task automatic send_frame(input bit with_hdr, input bit bad_cks);
        int          n = words.size();
        logic [15:0] n16 = 16'(n);
        logic [7:0]  cks = '0;
        logic [31:0] w;
        if (with_hdr) send_byte(SYNC);
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            if (i < DEPTH_A) exp_a.push_back({16'(i), w});
            if (i < DEPTH_B) exp_b.push_back({16'(i), w});
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8]);
                cks = cks ^ w[8*k +: 8];
            end
        end
        if (CKS) send_byte(bad_cks ? (cks ^ 8'h01) : cks);
        ok_a = (n <= DEPTH_A) && !(CKS && bad_cks);
        ok_b = (n <= DEPTH_B) && !(CKS && bad_cks);
    endtask

    task automatic check_status();
        idle(4);
        check("done_a", 48'(done_a), 48'(ok_a));
        check("cpu_rst_n_a", 48'(cpu_rst_n_a), 48'(ok_a));
        check("err_a", 48'(err_a), 48'(!ok_a));
        check("busy_a", 48'(busy_a), 48'd0);
        check("done_b", 48'(done_b), 48'(ok_b));
        check("cpu_rst_n_b", 48'(cpu_rst_n_b), 48'(ok_b));
        check("err_b", 48'(err_b), 48'(!ok_b));
        check("busy_b", 48'(busy_b), 48'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready_a", 48'(in_ready_a), 48'd1);
        check("rst_im_we_a", 48'(im_we_a), 48'd0);
        check("rst_im_waddr_a", 48'(im_waddr_a), 48'd0);
        check("rst_im_wdata_a", 48'(im_wdata_a), 48'd0);
        check("rst_cpu_rst_n_a", 48'(cpu_rst_n_a), 48'd0);
        check("rst_busy_a", 48'(busy_a), 48'd0);
        check("rst_done_a", 48'(done_a), 48'd0);
        check("rst_err_a", 48'(err_a), 48'd0);
        check("rst_flags_b", {44'b0, in_ready_b, cpu_rst_n_b, done_b, err_b}, 48'h8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load with exact end-of-load latency.
        words = '{32'h12345678, 32'hDEADBEEF};
        send_frame(1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (CKS ? 0 : 1) @(negedge clk);
        check("basic_cpu_rst_n_before", 48'(cpu_rst_n_a), 48'd0);
        @(negedge clk);
        check("basic_cpu_rst_n_on_time", 48'(cpu_rst_n_a), 48'd1);
        check("basic_done_on_time", 48'(done_a), 48'd1);
        check_status();

        // Header hunt and zero-length frame.
        send_byte(8'h00);
        send_byte(8'h11);
        words = {};
        send_frame(1'b1, 1'b0);
        check_status();

        // Three words: overflows the 2-word instance only.
        words = '{$urandom, $urandom, $urandom};
        send_frame(1'b1, 1'b0);
        check_status();

        // Reload after a successful load.
        send_byte(SYNC);
        check("reload_done_a", 48'(done_a), 48'd0);
        check("reload_cpu_rst_n_a", 48'(cpu_rst_n_a), 48'd0);
        check("reload_busy_a", 48'(busy_a), 48'd1);
        check("reload_err_cleared_b", 48'(err_b), 48'd0);
        words = '{$urandom};
        send_frame(1'b0, 1'b0);
        check_status();

        // Asynchronous reset in the middle of a word.
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h3C);
        send_byte(8'hC3);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Continuous in_valid across WRITE cycles.
        gaps = 1'b0;
        words = '{$urandom, $urandom, $urandom, $urandom, $urandom};
        send_frame(1'b1, 1'b0);
        check_status();

        // Checksum match then mismatch (mismatch is a no-op without the checksum option).
        words = '{32'h01020304};
        send_frame(1'b1, 1'b0);
        check_status();
        send_frame(1'b1, 1'b1);
        check_status();

        // Randomized frames with junk, idle gaps and embedded header bytes.
        gaps = 1'b1;
        for (int f = 0; f < 30; f++) begin
            for (int j = $urandom_range(3); j > 0; j--) begin
                w[7:0] = 8'($urandom);
                if (w[7:0] == SYNC) w[7:0] = 8'h5A;
                send_byte(w[7:0]);
            end
            words = {};
            for (int i = $urandom_range(5); i > 0; i--) begin
                w = $urandom;
                if ($urandom_range(3) == 0) w[8*$urandom_range(3) +: 8] = SYNC;
                words.push_back(w);
            end
            send_frame(1'b1, $urandom_range(3) == 0);
            check_status();
        end

        idle(3);
        check("exp_a_drained", 48'(exp_a.size()), 48'd0);
        check("exp_b_drained", 48'(exp_b.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm_imem_loader.md
Name: sm_imem_loader

Overview:
- Byte-stream bootloader upstream of the CPU's instruction memory.
- Receives a framed program image over a valid/ready byte interface and assembles it into 32-bit words, little-endian.
- Writes each word into the instruction memory write port.
- Holds the CPU in reset until a complete, valid image has been loaded; a new frame header re-enters load mode at any time.

Parameters:
- ADDR_WIDTH, 6: instruction memory word-address width; depth = 2^ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5: frame header byte.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  received byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte; a transfer occurs when in_valid & in_ready.
- im_we  output  1  instruction memory write enable, one-cycle pulse per word.
- im_waddr  output  ADDR_WIDTH  word address for the write.
- im_wdata  output  32  word to write.
- cpu_rst_n  output  1  active-low reset to the CPU core.
- busy  output  1  load in progress: state is LEN0, LEN1, DATA, WRITE or CHECK.
- done  output  1  image loaded; CPU running.
- err  output  1  sticky error flag; cleared when a SYNC_BYTE header is accepted.

Behaviour:
- All registers reset asynchronously on rst_n low. Reset values:
  - state = SYNC
  - im_we = 0, im_waddr = 0, im_wdata = 0
  - cpu_rst_n = 0, busy = 0, done = 0, err = 0
  - in_ready = 1 (decoded from state)
- in_ready = 0 only in WRITE; 1 in every other state.
- States: SYNC, LEN0, LEN1, DATA, WRITE, CHECK (CHECK only with the optional feature), RUN.
- SYNC: bytes other than SYNC_BYTE are consumed and discarded. On SYNC_BYTE: clear err, the word index and the byte counter, then go to LEN0.
- LEN0 / LEN1: capture the 16-bit word count N, low byte first.
  - After LEN1, if N == 0, go to RUN (or CHECK if the feature is enabled; the expected checksum is 0).
  - Otherwise go to DATA.
- DATA: shift bytes into a 32-bit assembly register; byte k of a word lands in bits [8k+7:8k]. After the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - im_we = 1, im_waddr = word index[ADDR_WIDTH-1:0], im_wdata = assembled word.
  - Word index increments.
  - If words remain, go to DATA; otherwise go to RUN (or CHECK).
- Overflow: if word index >= 2^ADDR_WIDTH, im_we stays 0 and err is set; the data is still consumed and the frame continues to the end. On reaching RUN with err = 1, go to SYNC instead; cpu_rst_n stays 0.
- RUN:
  - done = 1 and cpu_rst_n = 1, both registered, so they rise one cycle after RUN is entered.
  - Non-header bytes are ignored.
  - On SYNC_BYTE: go to LEN0 with the same clears as SYNC. cpu_rst_n and done drop to 0 on the next edge. The CPU stays in reset for the whole reload.
- im_we, im_waddr and im_wdata are registered; im_we is 0 outside WRITE.
- Latency: the 4th byte of a word accepted at edge t gives im_we = 1 during cycle t+1. For the last word, cpu_rst_n = 1 from cycle t+3 (no checksum).
- Word index is 16 bits wide and never wraps within a frame (N ≤ 65535).
- A SYNC_BYTE value inside LEN or DATA is treated as data, not as a header.
- rst_n asserted mid-frame: immediate return to reset values; partially assembled data is lost; memory contents already written are untouched.

Optional Feature:
- Macro: SM_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR of all DATA bytes is kept.
  - After the last WRITE (or LEN1 with N = 0), the CHECK state accepts one checksum byte.
  - Match and err = 0: go to RUN.
  - Mismatch: set err, go to SYNC; cpu_rst_n stays 0.
- Disabled: the CHECK state and XOR register are absent; the transition goes directly to RUN, and no checksum byte is expected.

Test Plan:
- Basic load: send A5, 02, 00, 78 56 34 12, EF BE AD DE (no checksum) -> im_we pulses twice: addr 0 data 32'h12345678, then addr 1 data 32'hDEADBEEF. done = 1, cpu_rst_n = 1 three cycles after the last byte; err = 0.
- Header hunt and zero length: send 00, 11, A5, 00, 00 -> no im_we pulse; RUN reached; cpu_rst_n = 1.
- Overflow: ADDR_WIDTH = 1, send N = 3 with three words -> writes at addr 0 and 1 only; err = 1; state returns to SYNC; cpu_rst_n stays 0.
- Reload and async reset: after a successful load, send A5 -> cpu_rst_n = 0 and done = 0 next cycle. Pull rst_n low mid-DATA -> all outputs at reset values immediately; no im_we.
- Backpressure: hold in_valid = 1 continuously -> in_ready = 0 on every WRITE cycle; no byte lost or duplicated (verify data matches the sent image).
- SM_LOADER_CHECKSUM_EN: word 32'h01020304 with checksum 04 -> RUN. Same word with checksum 05 -> err = 1, SYNC, cpu_rst_n = 0.
